// File: rtl/jtexterm_objscan_if.sv
// Bus bundle for the object scanner: VRAM scan port, GFX ROM slot and line buffer write port.
// The master modport belongs to the scanner; the slave modport faces the memories.
interface jtexterm_objscan_if #(
  parameter int AW  = 13,
  parameter int RAW = 20
);
  logic [AW-1:0]  scan_addr;
  logic [7:0]     scan_dout;
  logic [RAW-1:0] rom_addr;
  logic           rom_cs;
  logic [31:0]    rom_data;
  logic           rom_ok;
  logic [8:0]     buf_addr;
  logic [7:0]     buf_data;
  logic           buf_we;

  modport master (
    output scan_addr, rom_addr, rom_cs, buf_addr, buf_data, buf_we,
    input  scan_dout, rom_data, rom_ok
  );

  modport slave (
    input  scan_addr, rom_addr, rom_cs, buf_addr, buf_data, buf_we,
    output scan_dout, rom_data, rom_ok
  );
endinterface

// File: rtl/jtexterm_objscan.sv
// Exterminator per-line object scanner: walks the object table on each hs rise and draws 16x16 4bpp hits.
// Define JTEXTERM_OBJ_HFLIP_EN to honour the horizontal flip bit (entry byte 2, bit 7).
module jtexterm_objscan #(
  parameter int             OBJN    = 64,
  parameter int             AW      = 13,
  parameter logic [AW-1:0]  OBJBASE = '0,
  parameter int             RAW     = 20
)(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_hs,
  input  logic [8:0]        i_vdump,
  output logic              o_busy,
  jtexterm_objscan_if.master bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_DRAW  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  logic [2:0]     r_state;
  logic           r_hs_d;
  logic           r_busy;
  logic [7:0]     r_idx;
  logic [2:0]     r_cnt;
  logic [8:0]     r_vrender;
  logic [7:0]     r_y;
  logic [9:0]     r_code;
  logic [3:0]     r_pal;
  logic [8:0]     r_x;
  logic [3:0]     r_ydiff;
  logic           r_half;
  logic           r_stable;
  logic [31:0]    r_word;
  logic [AW-1:0]  r_scan_addr;
  logic [RAW-1:0] r_rom_addr;
  logic           r_rom_cs;
  logic [8:0]     r_buf_addr;
  logic [7:0]     r_buf_data;
  logic           r_buf_we;
`ifdef JTEXTERM_OBJ_HFLIP_EN
  logic           r_hflip;
`endif

  logic           w_hs_rise;
  logic [7:0]     w_ydiff;
  logic           w_hit;
  logic           w_last;
  logic [7:0]     w_next_idx;
  logic [AW-1:0]  w_next_base;
  logic           w_flip;
  logic [RAW-1:0] w_addr_h0;
  logic [RAW-1:0] w_addr_h1;
  logic [3:0]     w_nib;
  logic [8:0]     w_px;
  logic           w_obj_done;

  assign w_hs_rise   = i_hs & ~r_hs_d;
  assign w_ydiff     = r_vrender[7:0] - r_y;
  assign w_hit       = w_ydiff < 8'd16;
  assign w_last      = r_idx == 8'(OBJN - 1);
  assign w_next_idx  = r_idx + 8'd1;
  assign w_next_base = OBJBASE + AW'({w_next_idx, 2'b00});

  // With flip, half 0 (left 8 pixels) comes from the right half of the ROM row, nibbles reversed.
`ifdef JTEXTERM_OBJ_HFLIP_EN
  assign w_flip = r_hflip;
  assign w_nib  = r_hflip ? r_word[{~r_cnt, 2'b00} +: 4] : r_word[{r_cnt, 2'b00} +: 4];
`else
  assign w_flip = 1'b0;
  assign w_nib  = r_word[{r_cnt, 2'b00} +: 4];
`endif

  assign w_addr_h0 = RAW'({r_code, w_ydiff[3:0], w_flip});
  assign w_addr_h1 = RAW'({r_code, r_ydiff, ~w_flip});
  assign w_px      = r_x + {5'd0, r_half, r_cnt};

  // An object is finished either on a row miss or after the second half has been drawn.
  assign w_obj_done = ((r_state == ST_CHECK) && !w_hit) ||
                      ((r_state == ST_DRAW) && (r_cnt == 3'd7) && r_half);

  assign bus.scan_addr = r_scan_addr;
  assign bus.rom_addr  = r_rom_addr;
  assign bus.rom_cs    = r_rom_cs;
  assign bus.buf_addr  = r_buf_addr;
  assign bus.buf_data  = r_buf_data;
  assign bus.buf_we    = r_buf_we;
  assign o_busy        = r_busy;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_hs_d      <= 1'b0;
      r_busy      <= 1'b0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_vrender   <= '0;
      r_y         <= '0;
      r_code      <= '0;
      r_pal       <= '0;
      r_x         <= '0;
      r_ydiff     <= '0;
      r_half      <= 1'b0;
      r_stable    <= 1'b0;
      r_word      <= '0;
      r_scan_addr <= '0;
      r_rom_addr  <= '0;
      r_rom_cs    <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
      r_buf_we    <= 1'b0;
`ifdef JTEXTERM_OBJ_HFLIP_EN
      r_hflip     <= 1'b0;
`endif
    end else begin
      r_hs_d   <= i_hs;
      r_buf_we <= 1'b0;
      if (w_hs_rise) begin
        // A new line always wins, even mid-object; whatever was drawn stays in the buffer.
        r_state     <= ST_READ;
        r_busy      <= 1'b1;
        r_idx       <= '0;
        r_cnt       <= '0;
        r_half      <= 1'b0;
        r_rom_cs    <= 1'b0;
        r_scan_addr <= OBJBASE;
        r_vrender   <= i_vdump + 9'd1;
      end else begin
        case (r_state)
          ST_READ: begin
            // Byte n arrives one clock after its address, so bytes land on counts 1..4.
            case (r_cnt)
              3'd1: r_y <= bus.scan_dout;
              3'd2: r_code[7:0] <= bus.scan_dout;
              3'd3: begin
                r_x[8]       <= bus.scan_dout[6];
                r_code[9:8]  <= bus.scan_dout[5:4];
                r_pal        <= bus.scan_dout[3:0];
`ifdef JTEXTERM_OBJ_HFLIP_EN
                r_hflip      <= bus.scan_dout[7];
`endif
              end
              3'd4: r_x[7:0] <= bus.scan_dout;
              default: ;
            endcase
            if (r_cnt < 3'd3) r_scan_addr <= r_scan_addr + AW'(1);
            if (r_cnt == 3'd4) r_state <= ST_CHECK;
            else r_cnt <= r_cnt + 3'd1;
          end
          ST_CHECK: begin
            if (w_hit) begin
              r_ydiff    <= w_ydiff[3:0];
              r_half     <= 1'b0;
              r_rom_addr <= w_addr_h0;
              r_rom_cs   <= 1'b1;
              r_stable   <= 1'b0;
              r_state    <= ST_FETCH;
            end
          end
          ST_FETCH: begin
            // rom_ok is only trusted once the address has been on the bus for a full clock.
            r_stable <= 1'b1;
            if (r_stable && bus.rom_ok) begin
              r_word   <= bus.rom_data;
              r_rom_cs <= 1'b0;
              r_cnt    <= '0;
              r_state  <= ST_DRAW;
            end
          end
          ST_DRAW: begin
            r_buf_addr <= w_px;
            r_buf_data <= {r_pal, w_nib};
            r_buf_we   <= |w_nib;
            r_cnt      <= r_cnt + 3'd1;
            if (r_cnt == 3'd7 && !r_half) begin
              r_half     <= 1'b1;
              r_rom_addr <= w_addr_h1;
              r_rom_cs   <= 1'b1;
              r_stable   <= 1'b0;
              r_state    <= ST_FETCH;
            end
          end
          default: ;
        endcase

        if (w_obj_done) begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end else begin
            r_idx       <= w_next_idx;
            r_cnt       <= '0;
            r_half      <= 1'b0;
            r_scan_addr <= w_next_base;
            r_state     <= ST_READ;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtexterm_objscan.sv
// Self-checking bench for jtexterm_objscan: random tables and ROM latency against a line-level model.
// Expected flip behaviour follows whether JTEXTERM_OBJ_HFLIP_EN is defined for the build.
module tb_jtexterm_objscan;

  localparam int             OBJN      = 16;
  localparam int             AW        = 13;
  localparam int             RAW       = 20;
  localparam logic [AW-1:0]  OBJBASE   = 13'h0100;
  localparam int             LINE_CLKS = 512;
`ifdef JTEXTERM_OBJ_HFLIP_EN
  localparam bit HFLIP = 1'b1;
`else
  localparam bit HFLIP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       hs;
  logic [8:0] vdump;
  logic       busy;

  jtexterm_objscan_if #(.AW(AW), .RAW(RAW)) bus();

  jtexterm_objscan #(
    .OBJN(OBJN), .AW(AW), .OBJBASE(OBJBASE), .RAW(RAW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_hs(hs), .i_vdump(vdump), .o_busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  logic [7:0]     vram [0:(1<<AW)-1];
  logic [7:0]     lineBuf [0:511];
  logic [7:0]     expBuf  [0:511];
  int             writeCount;
  int             expWrites;
  logic [RAW-1:0] romLog[$];
  logic [RAW-1:0] expRom[$];
  logic           csPrev = 1'b0;
  logic           romFixedEn = 1'b0;
  logic [31:0]    romFixed = '0;
  int             romOkMode = 0;

  function automatic logic [31:0] romHash(input logic [RAW-1:0] a);
    logic [31:0] h, m;
    h = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A1234;
    m = (32'(a) ^ 32'h0000003C) * 32'h85EBCA6B;
    return h & (m | {m[15:0], m[31:16]});
  endfunction

  function automatic logic [31:0] romModel(input logic [RAW-1:0] a);
    return romFixedEn ? romFixed : romHash(a);
  endfunction

  always @(posedge clk) bus.scan_dout <= vram[bus.scan_addr];
  always_comb bus.rom_data = romFixedEn ? romFixed : romHash(bus.rom_addr);

  always @(negedge clk) begin
    case (romOkMode)
      0:       bus.rom_ok = 1'b1;
      1:       bus.rom_ok = ($urandom_range(0, 2) == 0);
      default: bus.rom_ok = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.buf_we) begin
      lineBuf[bus.buf_addr] = bus.buf_data;
      writeCount++;
    end
    if (bus.rom_cs && !csPrev) romLog.push_back(bus.rom_addr);
    csPrev = bus.rom_cs;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic setEntry(input int n, input logic [7:0] b0, b1, b2, b3);
    vram[int'(OBJBASE) + 4*n + 0] = b0;
    vram[int'(OBJBASE) + 4*n + 1] = b1;
    vram[int'(OBJBASE) + 4*n + 2] = b2;
    vram[int'(OBJBASE) + 4*n + 3] = b3;
  endtask

  // Every object parked far from line 0x40 so only explicitly placed ones hit.
  task automatic fillMiss();
    for (int n = 0; n < OBJN; n++) setEntry(n, 8'h80, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic clearLine();
    for (int i = 0; i < 512; i++) lineBuf[i] = 8'h00;
    writeCount = 0;
    romLog.delete();
  endtask

  // Line-level model: objects painted in table order, later ones overwrite earlier ones.
  task automatic buildModel(input logic [8:0] vd);
    logic [8:0]  vr;
    logic [7:0]  b [4];
    logic [7:0]  yd;
    logic [9:0]  code;
    logic [8:0]  x, px;
    logic        fl;
    logic [31:0] addr, w;
    logic [3:0]  nib;
    vr = vd + 9'd1;
    for (int i = 0; i < 512; i++) expBuf[i] = 8'h00;
    expRom.delete();
    expWrites = 0;
    for (int n = 0; n < OBJN; n++) begin
      for (int i = 0; i < 4; i++) b[i] = vram[int'(OBJBASE) + 4*n + i];
      yd = vr[7:0] - b[0];
      if (yd < 8'd16) begin
        code = {b[2][5:4], b[1]};
        x    = {b[2][6], b[3]};
        fl   = HFLIP ? b[2][7] : 1'b0;
        for (int h = 0; h < 2; h++) begin
          addr = 32'(code) * 32 + 32'(yd) * 2 + 32'(h ^ int'(fl));
          expRom.push_back(addr[RAW-1:0]);
          w = romModel(addr[RAW-1:0]);
          for (int k = 0; k < 8; k++) begin
            nib = fl ? w[28 - 4*k +: 4] : w[4*k +: 4];
            px  = 9'((int'(x) + 8*h + k) % 512);
            if (nib != 4'd0) begin
              expBuf[px] = {b[2][3:0], nib};
              expWrites++;
            end
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [8:0] vd, output int busyLen);
    clearLine();
    @(negedge clk);
    vdump = vd;
    hs    = 1'b1;
    @(negedge clk);
    hs      = 1'b0;
    busyLen = 0;
    while (busy && busyLen < 8*LINE_CLKS) begin
      busyLen++;
      @(negedge clk);
    end
    if (busy) checkOutput("line_timeout", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic compareLine(input string tag);
    int bad;
    int badRom;
    bad = 0;
    for (int i = 0; i < 512; i++) if (lineBuf[i] !== expBuf[i]) bad++;
    checkOutput({tag, "/buf"}, 32'(bad), 32'd0);
    checkOutput({tag, "/writes"}, 32'(writeCount), 32'(expWrites));
    checkOutput({tag, "/romN"}, 32'(romLog.size()), 32'(expRom.size()));
    badRom = 0;
    for (int i = 0; i < romLog.size() && i < expRom.size(); i++)
      if (romLog[i] !== expRom[i]) badRom++;
    checkOutput({tag, "/romAddr"}, 32'(badRom), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyLen, busyLen1, waitCnt, savedWrites;
    logic [8:0] vd;
    logic [7:0] vr8;

    rst = 1'b1; hs = 1'b0; vdump = '0; romOkMode = 0;
    for (int i = 0; i < (1<<AW); i++) vram[i] = 8'h00;
    clearLine();
    repeat (3) @(negedge clk);
    checkOutput("rst/scan_addr", 32'(bus.scan_addr), 32'd0);
    checkOutput("rst/rom_addr",  32'(bus.rom_addr),  32'd0);
    checkOutput("rst/rom_cs",    32'(bus.rom_cs),    32'd0);
    checkOutput("rst/buf_addr",  32'(bus.buf_addr),  32'd0);
    checkOutput("rst/buf_data",  32'(bus.buf_data),  32'd0);
    checkOutput("rst/buf_we",    32'(bus.buf_we),    32'd0);
    checkOutput("rst/busy",      32'(busy),          32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("idle/writes", 32'(writeCount), 32'd0);
    checkOutput("idle/busy",   32'(busy),       32'd0);

    $display("[TB] single object, opaque row");
    fillMiss();
    setEntry(0, 8'h38, 8'h05, 8'h03, 8'h20);
    romFixedEn = 1'b1; romFixed = 32'h8765_4321;
    buildModel(9'h03F);
    applyStimulus(9'h03F, busyLen1);
    compareLine("t1");
    checkOutput("t1/rom0", 32'(romLog.size() > 0 ? romLog[0] : '1), 32'h000B0);
    checkOutput("t1/rom1", 32'(romLog.size() > 1 ? romLog[1] : '1), 32'h000B1);
    checkOutput("t1/x20",  32'(lineBuf[9'h020]), 32'h31);
    checkOutput("t1/x2F",  32'(lineBuf[9'h02F]), 32'h38);
    checkOutput("t1/busyLen", 32'(busyLen1), 32'((OBJN-1)*6 + 26));

    $display("[TB] transparent pixels");
    romFixed = 32'h0000_00F1;
    buildModel(9'h03F);
    applyStimulus(9'h03F, busyLen);
    compareLine("t2");
    checkOutput("t2/writes4", 32'(writeCount), 32'd4);
    checkOutput("t2/x21", 32'(lineBuf[9'h021]), 32'h3F);
    checkOutput("t2/sameLen", 32'(busyLen), 32'(busyLen1));

    $display("[TB] x wrap");
    romFixed = 32'h8765_4321;
    setEntry(0, 8'h38, 8'h05, 8'h43, 8'hFC);
    buildModel(9'h03F);
    applyStimulus(9'h03F, busyLen);
    compareLine("t3");
    checkOutput("t3/x1FC", 32'(lineBuf[9'h1FC]), 32'h31);
    checkOutput("t3/x000", 32'(lineBuf[9'h000]), 32'h35);
    checkOutput("t3/x00B", 32'(lineBuf[9'h00B]), 32'h38);

    $display("[TB] flip bit");
    setEntry(0, 8'h38, 8'h05, 8'h83, 8'h20);
    buildModel(9'h03F);
    applyStimulus(9'h03F, busyLen);
    compareLine("t4");
    checkOutput("t4/rom0", 32'(romLog.size() > 0 ? romLog[0] : '1), HFLIP ? 32'h000B1 : 32'h000B0);
    checkOutput("t4/x20", 32'(lineBuf[9'h020]), HFLIP ? 32'h38 : 32'h31);

    $display("[TB] every object hits, immediate ROM");
    romFixedEn = 1'b0;
    vd  = 9'($urandom_range(0, 511));
    vr8 = 8'(vd + 9'd1);
    for (int n = 0; n < OBJN; n++)
      setEntry(n, vr8 - 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom));
    buildModel(vd);
    applyStimulus(vd, busyLen);
    compareLine("t5");
    checkOutput("t5/busyLen", 32'(busyLen), 32'(OBJN*26));
    checkOutput("t5/fitsLine", 32'(busyLen <= LINE_CLKS), 32'd1);

    $display("[TB] random tables, random ROM latency");
    romOkMode = 1;
    for (int it = 0; it < 6; it++) begin
      vd  = 9'($urandom_range(0, 511));
      vr8 = 8'(vd + 9'd1);
      for (int n = 0; n < OBJN; n++)
        setEntry(n, vr8 - 8'($urandom_range(0, 31)), 8'($urandom), 8'($urandom), 8'($urandom));
      buildModel(vd);
      applyStimulus(vd, busyLen);
      compareLine("rand");
    end

    $display("[TB] abort during fetch");
    fillMiss();
    setEntry(0, 8'h38, 8'h05, 8'h03, 8'h20);
    romOkMode = 2;
    clearLine();
    @(negedge clk); vdump = 9'h03F; hs = 1'b1;
    @(negedge clk); hs = 1'b0;
    waitCnt = 0;
    while (!bus.rom_cs && waitCnt < 60) begin
      waitCnt++;
      @(negedge clk);
    end
    checkOutput("abort/reachFetch", 32'(bus.rom_cs), 32'd1);
    vdump = 9'h010; hs = 1'b1;
    @(negedge clk);
    hs = 1'b0;
    checkOutput("abort/rom_cs",    32'(bus.rom_cs),    32'd0);
    checkOutput("abort/buf_we",    32'(bus.buf_we),    32'd0);
    checkOutput("abort/scan_addr", 32'(bus.scan_addr), 32'(OBJBASE));
    checkOutput("abort/busy",      32'(busy),          32'd1);
    romOkMode = 0;
    waitCnt = 0;
    while (busy && waitCnt < 4*LINE_CLKS) begin
      waitCnt++;
      @(negedge clk);
    end
    checkOutput("abort/done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("abort/writes", 32'(writeCount), 32'd0);
    checkOutput("abort/romN", 32'(romLog.size()), 32'd1);

    $display("[TB] reset mid-line");
    vd  = 9'h100;
    vr8 = 8'(vd + 9'd1);
    for (int n = 0; n < OBJN; n++)
      setEntry(n, vr8 - 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom));
    clearLine();
    @(negedge clk); vdump = vd; hs = 1'b1;
    @(negedge clk); hs = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst/busy",      32'(busy),          32'd0);
    checkOutput("midrst/rom_cs",    32'(bus.rom_cs),    32'd0);
    checkOutput("midrst/buf_we",    32'(bus.buf_we),    32'd0);
    checkOutput("midrst/scan_addr", 32'(bus.scan_addr), 32'd0);
    savedWrites = writeCount;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midrst/noWrites", 32'(writeCount), 32'(savedWrites));
    checkOutput("midrst/idle",     32'(busy),       32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
